// File: rtl/mul_share_rr_sched_pkg.sv
// Shared types and default widths for the round-robin multiplier scheduler.
package mul_share_pkg;
  localparam int DEF_A_W  = 8;
  localparam int DEF_B_W  = 6;
  localparam int DEF_P_W  = DEF_A_W + DEF_B_W;
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic signed [DEF_A_W-1:0] a;
    logic        [DEF_B_W-1:0] b;
    logic        [MAX_ID_W-1:0] id;
  } s1_t;

  typedef struct packed {
    logic signed [DEF_P_W-1:0] p;
    logic        [MAX_ID_W-1:0] id;
  } s2_t;

  // b is zero-extended so the signed multiply treats it as unsigned; the result always fits in P_W
  function automatic logic signed [DEF_P_W-1:0] smul_su(logic signed [DEF_A_W-1:0] a,
                                                        logic [DEF_B_W-1:0] b);
    logic signed [DEF_P_W-1:0] ax, bx;
    ax = {{(DEF_P_W-DEF_A_W){a[DEF_A_W-1]}}, a};
    bx = {{(DEF_P_W-DEF_B_W){1'b0}}, b};
    return ax * bx;
  endfunction
endpackage

// File: rtl/mul_share_rr_sched_if.sv
// Requester operand bus plus result channel of the shared multiplier.
interface mul_share_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 8,
  parameter int B_W     = 6,
  parameter int P_W     = 14,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [P_W-1:0]         res_data;
  logic [ID_W-1:0]        res_id;

  modport master (output req_valid, req_a, req_b, res_ready,
                  input  req_ready, res_valid, res_data, res_id);
  modport slave  (input  req_valid, req_a, req_b, res_ready,
                  output req_ready, res_valid, res_data, res_id);
endinterface

// File: rtl/mul_share_rr_sched_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping; gnt gated by en.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    gnt = '0;
    // k is the rotational distance from ptr; the smallest distance wins
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!any && req[i] && (((i - int'(ptr) + NUM_REQ) % NUM_REQ) == k)) begin
          any = 1'b1;
          idx = ID_W'(i);
        end
    for (int i = 0; i < NUM_REQ; i++)
      gnt[i] = en & any & (idx == ID_W'(i));
  end
endmodule

// File: rtl/mul_share_rr_sched.sv
// Shares one signed x unsigned multiplier among NUM_REQ requesters, 2-stage pipe.
// Optional MUL_SHARE_PERF_CNT_EN adds saturating busy/stall counters.
module mul_share_rr_sched
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W,
  parameter int ID_W    = 2
) (
  input logic ap_clk,
  input logic ap_rst,
  mul_share_rr_sched_if.slave bus
`ifdef MUL_SHARE_PERF_CNT_EN
  ,
  output logic [31:0] perf_busy_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  logic [2:1]             vld_pipe;
  s1_t                    s1;
  s2_t                    s2;
  logic [ID_W-1:0]        ptr, win;
  logic                   any, s2_load, s1_adv, grant_ok, hs;
  logic signed [A_W-1:0]  a_sel;
  logic [B_W-1:0]         b_sel;

  assign s2_load  = ~vld_pipe[2] | bus.res_ready;
  assign s1_adv   = vld_pipe[1] & s2_load;
  assign grant_ok = ~vld_pipe[1] | s1_adv;
  assign hs       = any & grant_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (grant_ok),
    .gnt (bus.req_ready),
    .idx (win),
    .any (any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == ID_W'(i)) begin
        a_sel = bus.req_a[i*A_W +: A_W];
        b_sel = bus.req_b[i*B_W +: B_W];
      end
  end

  // payload registers only load with live data so res_* stay frozen under backpressure
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_pipe <= '0;
      ptr      <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= '{p: smul_su(s1.a, s1.b), id: s1.id};
      end
      if (grant_ok) begin
        vld_pipe[1] <= hs;
        if (hs) s1 <= '{a: a_sel, b: b_sel, id: MAX_ID_W'(win)};
      end
      if (hs) ptr <= ID_W'((int'(win) + 1) % NUM_REQ);
    end
  end

  assign bus.res_valid = vld_pipe[2];
  assign bus.res_data  = s2.p;
  assign bus.res_id    = ID_W'(s2.id);

`ifdef MUL_SHARE_PERF_CNT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      perf_busy_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (vld_pipe[2] & bus.res_ready & ~&perf_busy_cnt)
        perf_busy_cnt <= perf_busy_cnt + 32'd1;
      if (|bus.req_valid & ~grant_ok & ~&perf_stall_cnt)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mul_share_rr_sched.sv
// Directed + random bench for mul_share_rr_sched against a queue-based model.
module tb_mul_share_rr_sched;
  localparam int N = 4;

  logic ap_clk, ap_rst;
  mul_share_rr_sched_if #(.NUM_REQ(N), .A_W(8), .B_W(6), .P_W(14), .ID_W(2)) bus ();
`ifdef MUL_SHARE_PERF_CNT_EN
  logic [31:0] perf_busy_cnt, perf_stall_cnt;
`endif

  mul_share_rr_sched #(.NUM_REQ(N), .A_W(8), .B_W(6), .P_W(14), .ID_W(2)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
`ifdef MUL_SHARE_PERF_CNT_EN
    ,
    .perf_busy_cnt  (perf_busy_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0, n_err = 0;
  logic [N-1:0] pend;
  int opa [N];
  int opb [N];
  bit refill, rr;
  int ptr_m, cyc, busy_m, stall_m, dut_hs;
  int q_id [$];
  int q_p  [$];
  int q_c  [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic newops(int i);
    pend[i] = 1'b1;
    opa[i]  = int'($urandom_range(0, 255)) - 128;
    opb[i]  = int'($urandom_range(0, 63));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = pend[i];
      bus.req_a[i*8 +: 8]    = 8'(opa[i]);
      bus.req_b[i*6 +: 6]    = 6'(opb[i]);
    end
    bus.res_ready = rr;
  endtask

  // one clock of the model: the pipe holds at most two products, delivered in grant order
  task automatic cycle();
    int w, occ;
    bit gok, rv;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    if (ap_rst) begin
      q_id.delete(); q_p.delete(); q_c.delete();
      ptr_m = 0; busy_m = 0; stall_m = 0;
    end else begin
      occ = q_id.size();
      gok = (occ < 2) || rr;
      rv  = (occ > 0) && ((cyc - q_c[0]) >= 2);
      w   = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      exp_rdy = (w >= 0 && gok) ? N'(1 << w) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("res_valid", 32'(bus.res_valid), 32'(rv));
      if (rv) begin
        chk("res_data", 32'(bus.res_data), 32'(q_p[0] & 32'h3FFF));
        chk("res_id",   32'(bus.res_id),   32'(q_id[0]));
      end
      dut_hs += $countones(bus.req_ready & bus.req_valid);
      if (rv && rr) begin
        void'(q_id.pop_front()); void'(q_p.pop_front()); void'(q_c.pop_front());
        busy_m++;
      end
      if (|pend && !gok) stall_m++;
      if (w >= 0 && gok) begin
        q_id.push_back(w); q_p.push_back(opa[w] * opb[w]); q_c.push_back(cyc);
        ptr_m = (w + 1) % N;
        if (refill) newops(w); else pend[w] = 1'b0;
      end
    end
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    refill = 1'b0; pend = '0; rr = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic single(int id, int a, int b, logic [13:0] expv, string tag);
    refill = 1'b0; rr = 1'b1;
    pend[id] = 1'b1; opa[id] = a; opb[id] = b;
    cycle();
    cycle();
    drive();
    #1;
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.res_data),  32'(expv));
    chk({tag, "_id"},    32'(bus.res_id),    32'(id));
    idle(2);
  endtask

  initial begin
    int h0;
    pend = '0; rr = 1'b1; refill = 1'b0;
    for (int i = 0; i < N; i++) begin opa[i] = 0; opb[i] = 0; end
    ptr_m = 0; cyc = 0; busy_m = 0; stall_m = 0; dut_hs = 0;
    ap_rst = 1'b1;
    cycle(); cycle();
    ap_rst = 1'b0;
    drive();
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_res_id",    32'(bus.res_id),    32'd0);
`ifdef MUL_SHARE_PERF_CNT_EN
    chk("rst_busy",  perf_busy_cnt,  32'd0);
    chk("rst_stall", perf_stall_cnt, 32'd0);
`endif

    // requester 2 alone: same-cycle grant, product two cycles later
    pend[2] = 1'b1; opa[2] = -128; opb[2] = 63;
    drive();
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    pend[2] = 1'b0;
    single(2, -128, 63, 14'h2080, "min");
    single(0, 127, 63, 14'h1F41, "max");
    single(1, -1, 0, 14'h0000, "zero");

    // all requesters streaming with continuous res_ready
    refill = 1'b1; rr = 1'b1;
    for (int i = 0; i < N; i++) newops(i);
    for (int i = 0; i < 12; i++) cycle();
    idle(3);

    // backpressure from an empty pipe: exactly two accepts, then stall
    refill = 1'b1; rr = 1'b0;
    for (int i = 0; i < N; i++) newops(i);
    h0 = dut_hs;
    for (int i = 0; i < 6; i++) cycle();
    chk("bp_handshakes", 32'(dut_hs - h0), 32'd2);
    rr = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    idle(3);

    // random arrivals and random downstream stalls
    refill = 1'b0;
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) newops(i);
      rr = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle(3);
`ifdef MUL_SHARE_PERF_CNT_EN
    chk("perf_busy",  perf_busy_cnt,  32'(busy_m));
    chk("perf_stall", perf_stall_cnt, 32'(stall_m));
`endif

    // reset with both stages full: in-flight products vanish, ptr back to 0
    refill = 1'b1; rr = 1'b0;
    for (int i = 0; i < N; i++) newops(i);
    for (int i = 0; i < 4; i++) cycle();
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    refill = 1'b0; pend = '0; rr = 1'b1;
    drive();
    #1;
    chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
`ifdef MUL_SHARE_PERF_CNT_EN
    chk("mid_rst_busy",  perf_busy_cnt,  32'd0);
    chk("mid_rst_stall", perf_stall_cnt, 32'd0);
`endif
    for (int i = 0; i < N; i++) newops(i);
    drive();
    #1;
    chk("post_rst_grant0", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 10; i++) cycle();
    idle(4);
    chk("drained", 32'(q_id.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
